cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_arb_grant.sv | 26 ++
 rtl/cache_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: types and encodings shared by the cache arbiter and the
// direct-mapped cache controller.
//   - arb_state_e : arbiter FSM states
//   - grant_t     : which requester owns the downstream port
//   - CMD_WRITE / CMD_READ : encodings on the *_wr lines
package cache_pkg;

  // Request command encodings on the *_wr lines
  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  // Grant index: 0 selects requester m0, 1 selects requester m1
  typedef logic grant_t;

  localparam grant_t GRANT_M0 = 1'b0;
  localparam grant_t GRANT_M1 = 1'b1;

  // The requester that did not receive grant g
  function automatic grant_t other_grant(input grant_t g);
    return (g == GRANT_M0) ? GRANT_M1 : GRANT_M0;
  endfunction

endpackage

// File: rtl/cache_arb_grant.sv
// cache_arb_grant: purely combinational 2-way selector.
// A lone requester always wins. When both request, prio_i names the winner.
// With a constant prio_i of GRANT_M0 this is fixed priority; with a rotating
// prio_i it becomes round-robin.
module cache_arb_grant
  import cache_pkg::*;
(
  input  logic [1:0] req_i,
  input  grant_t     prio_i,
  output logic       valid_o,
  output grant_t     grant_o
);

  // Pick the winning requester from the request vector and the tie-break hint
  always_comb begin
    valid_o = |req_i;
    grant_o = GRANT_M0;
    unique case (req_i)
      2'b01:   grant_o = GRANT_M0;
      2'b10:   grant_o = GRANT_M1;
      2'b11:   grant_o = prio_i;
      default: grant_o = GRANT_M0;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: arbitrates two requesters (m0, m1) onto the single
// request/response port of the direct-mapped cache controller.
// Only one transaction is in flight at a time:
//   IDLE  -> accept a request and latch its fields
//   ISSUE -> present the request downstream until it is handshaken
//   BUSY  -> wait for the read data, or the write completion
// Optional build macro CACHE_ARB_ROUND_ROBIN_EN:
//   - defined   : ties alternate between the two requesters.
//   - undefined : fixed priority, m0 always wins a tie.
module cache_arbiter
  import cache_pkg::*;
#(
  parameter int Addresswidth = 25
) (
  input  logic                    clk,
  input  logic                    rstn,

  // Requester 0
  input  logic [Addresswidth-1:0] m0_addr,
  input  logic [31:0]             m0_data,
  input  logic                    m0_wr,
  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  output logic [31:0]             m0_rsp_data,
  output logic                    m0_rsp_valid,

  // Requester 1
  input  logic [Addresswidth-1:0] m1_addr,
  input  logic [31:0]             m1_data,
  input  logic                    m1_wr,
  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  output logic [31:0]             m1_rsp_data,
  output logic                    m1_rsp_valid,

  // Cache controller
  output logic [Addresswidth-1:0] c_addr,
  output logic [31:0]             c_data,
  output logic                    c_wr,
  output logic                    c_req_valid,
  input  logic                    c_req_ready,
  input  logic [31:0]             c_rsp_data,
  input  logic                    c_rsp_valid
);

  arb_state_e              state_q, state_d;
  logic [Addresswidth-1:0] addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic                    wr_q, wr_d;
  grant_t                  grant_q, grant_d;

  logic [1:0]              req_vec;
  grant_t                  prio;
  logic                    sel_valid;
  grant_t                  sel;
  logic                    accept;
  logic                    rsp_fire;
  logic [31:0]             rsp_data;

  assign req_vec = {m1_req_valid, m0_req_valid};

  cache_arb_grant u_grant (
    .req_i   (req_vec),
    .prio_i  (prio),
    .valid_o (sel_valid),
    .grant_o (sel)
  );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // prio_q names the requester that wins the next tie. It is reset to m0.
  // After each accepted request it moves to the requester that just lost.
  grant_t prio_q, prio_d;

  // Tie-break hint advances only when a request is actually accepted
  always_comb begin
    prio_d = prio_q;
    if (accept) begin
      prio_d = other_grant(sel);
    end
  end

  // Tie-break hint register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio_q <= GRANT_M0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio = prio_q;
`else
  assign prio = GRANT_M0;
`endif

  // Next-state and handshake decode. While rstn is low, nothing is accepted
  // and no response is produced, so an in-flight transaction is dropped
  // silently.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    grant_d  = grant_q;
    accept   = 1'b0;
    rsp_fire = 1'b0;
    if (rstn) begin
      unique case (state_q)
        IDLE: begin
          if (sel_valid) begin
            accept  = 1'b1;
            grant_d = sel;
            addr_d  = (sel == GRANT_M1) ? m1_addr : m0_addr;
            data_d  = (sel == GRANT_M1) ? m1_data : m0_data;
            wr_d    = (sel == GRANT_M1) ? m1_wr   : m0_wr;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (c_req_ready) begin
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (wr_q == CMD_READ) begin
            if (c_rsp_valid) begin
              rsp_fire = 1'b1;
              state_d  = IDLE;
            end
          end else if (c_req_ready) begin
            rsp_fire = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      grant_q <= GRANT_M0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      grant_q <= grant_d;
    end
  end

  // A read returns the controller data. A write completion carries zero.
  assign rsp_data = (wr_q == CMD_READ) ? c_rsp_data : 32'd0;

  assign m0_req_ready = accept && (sel == GRANT_M0);
  assign m1_req_ready = accept && (sel == GRANT_M1);

  assign m0_rsp_valid = rsp_fire && (grant_q == GRANT_M0);
  assign m1_rsp_valid = rsp_fire && (grant_q == GRANT_M1);
  assign m0_rsp_data  = m0_rsp_valid ? rsp_data : 32'd0;
  assign m1_rsp_data  = m1_rsp_valid ? rsp_data : 32'd0;

  assign c_req_valid  = (state_q == ISSUE);
  assign c_addr       = addr_q;
  assign c_data       = data_q;
  assign c_wr         = wr_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed, self-checking bench for cache_arbiter.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// 1 time unit after that.
module tb_cache_arbiter;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] m0_addr, m1_addr, c_addr;
  logic [31:0]   m0_data, m1_data, c_data;
  logic          m0_wr, m1_wr, c_wr;
  logic          m0_req_valid, m1_req_valid, c_req_valid;
  logic          m0_req_ready, m1_req_ready, c_req_ready;
  logic [31:0]   m0_rsp_data, m1_rsp_data, c_rsp_data;
  logic          m0_rsp_valid, m1_rsp_valid, c_rsp_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.Addresswidth(AW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m0_addr      (m0_addr),
    .m0_data      (m0_data),
    .m0_wr        (m0_wr),
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_rsp_data  (m0_rsp_data),
    .m0_rsp_valid (m0_rsp_valid),
    .m1_addr      (m1_addr),
    .m1_data      (m1_data),
    .m1_wr        (m1_wr),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_rsp_data  (m1_rsp_data),
    .m1_rsp_valid (m1_rsp_valid),
    .c_addr       (c_addr),
    .c_data       (c_data),
    .c_wr         (c_wr),
    .c_req_valid  (c_req_valid),
    .c_req_ready  (c_req_ready),
    .c_rsp_data   (c_rsp_data),
    .c_rsp_valid  (c_rsp_valid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset held 3 cycles with m0 requesting; accept right after release
  task automatic test_reset();
    rstn = 1'b0; m0_req_valid = 1'b1; m0_addr = 25'h0000ABC; m0_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      checks++; if (m0_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_m0_ready cyc%0d: got %0b want 0", i, m0_req_ready); end
      checks++; if (c_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_c_valid cyc%0d: got %0b want 0", i, c_req_valid); end
      checks++; if (m0_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid cyc%0d: got %0b want 0", i, m0_rsp_valid); end
    end
    rstn = 1'b1;
    #1;
    checks++; if (m0_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_accept_m0: got %0b want 1", m0_req_ready); end
    checks++; if (m1_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_accept_m1: got %0b want 0", m1_req_ready); end
    cyc();
    m0_req_valid = 1'b0;
    #1;
    checks++; if (c_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL reset_issue_valid: got %0b want 1", c_req_valid); end
    checks++; if (c_addr !== 25'h0000ABC) begin failures++; $display("[TB] FAIL reset_issue_addr: got %h want 0000abc", c_addr); end
    // Abandon the request waiting in ISSUE
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    #1;
    checks++; if (c_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_abandon_issue: got %0b want 0", c_req_valid); end
  endtask

  // m0 read, data returned 4 cycles after acceptance
  task automatic test_single_read();
    m0_addr = 25'h0000123; m0_wr = 1'b1; m0_req_valid = 1'b1; c_req_ready = 1'b1;
    #1;
    checks++; if (m0_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL read_accept: got %0b want 1", m0_req_ready); end
    cyc();
    m0_req_valid = 1'b0;
    #1;
    checks++; if (c_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL read_c_valid: got %0b want 1", c_req_valid); end
    checks++; if (c_addr !== 25'h0000123) begin failures++; $display("[TB] FAIL read_c_addr: got %h want 0000123", c_addr); end
    checks++; if (c_wr !== 1'b1) begin failures++; $display("[TB] FAIL read_c_wr: got %0b want 1", c_wr); end
    cyc();
    c_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (m0_rsp_valid !== 1'b0 || m0_rsp_data !== 32'd0) begin failures++; $display("[TB] FAIL read_wait%0d: got v=%0b d=%h want v=0 d=0", i, m0_rsp_valid, m0_rsp_data); end
      checks++; if (c_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL read_busy_c_valid%0d: got %0b want 0", i, c_req_valid); end
      cyc();
    end
    c_rsp_valid = 1'b1; c_rsp_data = 32'hDEADBEEF;
    #1;
    checks++; if (m0_rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL read_rsp_valid: got %0b want 1", m0_rsp_valid); end
    checks++; if (m0_rsp_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL read_rsp_data: got %h want deadbeef", m0_rsp_data); end
    checks++; if (m1_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL read_m1_rsp: got %0b want 0", m1_rsp_valid); end
    cyc();
    c_req_ready = 1'b1;
    #1;
    checks++; if (m0_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL read_rsp_one_cycle: got %0b want 0", m0_rsp_valid); end
    c_rsp_valid = 1'b0; c_rsp_data = 32'd0;
  endtask

  // m1 write; the controller holds ready low for 2 cycles in BUSY
  task automatic test_single_write();
    m1_addr = 25'h1FFFFFF; m1_data = 32'hCAFEF00D; m1_wr = 1'b0; m1_req_valid = 1'b1; c_req_ready = 1'b1;
    #1;
    checks++; if (m1_req_ready !== 1'b1 || m0_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL write_accept: got m1=%0b m0=%0b want m1=1 m0=0", m1_req_ready, m0_req_ready); end
    cyc();
    m1_req_valid = 1'b0;
    #1;
    checks++; if (c_data !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL write_c_data: got %h want cafef00d", c_data); end
    checks++; if (c_addr !== 25'h1FFFFFF) begin failures++; $display("[TB] FAIL write_c_addr: got %h want 1ffffff", c_addr); end
    checks++; if (c_wr !== 1'b0 || c_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL write_c_ctrl: got wr=%0b v=%0b want wr=0 v=1", c_wr, c_req_valid); end
    cyc();
    c_req_ready = 1'b0; c_rsp_data = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (m1_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL write_wait%0d: got %0b want 0", i, m1_rsp_valid); end
      cyc();
    end
    c_req_ready = 1'b1;
    #1;
    checks++; if (m1_rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL write_rsp_valid: got %0b want 1", m1_rsp_valid); end
    checks++; if (m1_rsp_data !== 32'd0) begin failures++; $display("[TB] FAIL write_rsp_data: got %h want 0", m1_rsp_data); end
    checks++; if (m0_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL write_m0_rsp: got %0b want 0", m0_rsp_valid); end
    cyc();
    c_rsp_data = 32'd0;
    #1;
    checks++; if (m1_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL write_rsp_one_cycle: got %0b want 0", m1_rsp_valid); end
  endtask

  // Both requesters hold valid through 4 back-to-back reads
  task automatic test_contention();
    logic expg;
    logic [AW-1:0] expaddr;
    rstn = 1'b0;
    m0_addr = 25'h00000AA; m0_wr = 1'b1; m0_req_valid = 1'b1;
    m1_addr = 25'h00000BB; m1_wr = 1'b1; m1_req_valid = 1'b1;
    c_req_ready = 1'b1;
    cyc();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      expg = (k % 2 == 1);
`else
      expg = 1'b0;
`endif
      expaddr = expg ? 25'h00000BB : 25'h00000AA;
      #1;
      checks++; if (m0_req_ready !== !expg || m1_req_ready !== expg) begin failures++; $display("[TB] FAIL contend_grant%0d: got m0=%0b m1=%0b want grant %0d", k, m0_req_ready, m1_req_ready, expg); end
      cyc();
      #1;
      checks++; if (c_req_valid !== 1'b1 || c_addr !== expaddr) begin failures++; $display("[TB] FAIL contend_issue%0d: got v=%0b a=%h want v=1 a=%h", k, c_req_valid, c_addr, expaddr); end
      checks++; if (m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL contend_ready_issue%0d: got m0=%0b m1=%0b want 0 0", k, m0_req_ready, m1_req_ready); end
      cyc();
      c_rsp_valid = 1'b1; c_rsp_data = 32'h1000 + k;
      if (k == 3) begin
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
      end
      #1;
      checks++; if ((expg ? m1_rsp_valid : m0_rsp_valid) !== 1'b1 || (expg ? m0_rsp_valid : m1_rsp_valid) !== 1'b0) begin failures++; $display("[TB] FAIL contend_rsp%0d: got m0=%0b m1=%0b want grant %0d", k, m0_rsp_valid, m1_rsp_valid, expg); end
      checks++; if ((expg ? m1_rsp_data : m0_rsp_data) !== 32'h1000 + k) begin failures++; $display("[TB] FAIL contend_rsp_data%0d: got m0=%h m1=%h want %h", k, m0_rsp_data, m1_rsp_data, 32'h1000 + k); end
      cyc();
      c_rsp_valid = 1'b0; c_rsp_data = 32'd0;
    end
  endtask

  // Downstream stalls in ISSUE while m0 changes inputs; stray rsp ignored
  task automatic test_backpressure();
    m0_addr = 25'h00ABCDE; m0_data = 32'h11112222; m0_wr = 1'b1; m0_req_valid = 1'b1; c_req_ready = 1'b0;
    #1;
    checks++; if (m0_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_accept: got %0b want 1", m0_req_ready); end
    cyc();
    m0_addr = 25'h1555555; m0_data = 32'h99998888; m0_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c_rsp_valid = (i == 2); c_rsp_data = 32'hFFFF0000;
      #1;
      checks++; if (c_req_valid !== 1'b1 || c_addr !== 25'h00ABCDE) begin failures++; $display("[TB] FAIL bp_hold%0d: got v=%0b a=%h want v=1 a=0abcde", i, c_req_valid, c_addr); end
      checks++; if (c_data !== 32'h11112222 || c_wr !== 1'b1) begin failures++; $display("[TB] FAIL bp_fields%0d: got d=%h wr=%0b want d=11112222 wr=1", i, c_data, c_wr); end
      checks++; if (m0_req_ready !== 1'b0 || m0_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_quiet%0d: got rdy=%0b rsp=%0b want 0 0", i, m0_req_ready, m0_rsp_valid); end
      cyc();
    end
    c_rsp_valid = 1'b0; c_req_ready = 1'b1;
    cyc();
    m0_req_valid = 1'b0;
    c_rsp_valid = 1'b1; c_rsp_data = 32'h0BADCAFE;
    #1;
    checks++; if (m0_rsp_valid !== 1'b1 || m0_rsp_data !== 32'h0BADCAFE) begin failures++; $display("[TB] FAIL bp_rsp: got v=%0b d=%h want v=1 d=0badcafe", m0_rsp_valid, m0_rsp_data); end
    cyc();
    c_rsp_valid = 1'b0; c_rsp_data = 32'd0;
  endtask

  // Reset during a BUSY read, then a late response must be dropped
  task automatic test_reset_mid_busy();
    m0_addr = 25'h0000042; m0_wr = 1'b1; m0_req_valid = 1'b1; c_req_ready = 1'b1;
    cyc();
    m0_req_valid = 1'b0;
    cyc();
    rstn = 1'b0; c_rsp_valid = 1'b1; c_rsp_data = 32'h55AA55AA;
    #1;
    checks++; if (m0_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rbusy_in_reset: got %0b want 0", m0_rsp_valid); end
    cyc();
    rstn = 1'b1;
    #1;
    checks++; if (m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rbusy_late_rsp: got m0=%0b m1=%0b want 0 0", m0_rsp_valid, m1_rsp_valid); end
    checks++; if (m0_rsp_data !== 32'd0) begin failures++; $display("[TB] FAIL rbusy_rsp_data: got %h want 0", m0_rsp_data); end
    cyc();
    c_rsp_valid = 1'b0; c_rsp_data = 32'd0; m1_wr = 1'b1; m1_req_valid = 1'b1;
    #1;
    checks++; if (m1_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rbusy_idle: got %0b want 1", m1_req_ready); end
    cyc();
    m1_req_valid = 1'b0;
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    m0_addr = '0; m0_data = '0; m0_wr = 1'b0; m0_req_valid = 1'b0;
    m1_addr = '0; m1_data = '0; m1_wr = 1'b0; m1_req_valid = 1'b0;
    c_req_ready = 1'b0; c_rsp_data = '0; c_rsp_valid = 1'b0;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_backpressure();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
